// File: rtl/shinku_ma_pkg.sv
// Shared types and sizing helpers for the MemoryAccess-stage data-memory sequencer.
// Provides the sequencer state enum, default widths and beat-count / index-width helpers.
package shinku_ma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_DATA_W     = 1048;
    localparam int unsigned DEF_BEAT_W     = 128;
    localparam int unsigned BYTES_PER_BEAT = DEF_BEAT_W / 8;

    // Number of beats needed to carry dw bits over a bw-bit port.
    function automatic int unsigned calc_nbeats(input int unsigned dw, input int unsigned bw);
        return (dw + bw - 1) / bw;
    endfunction

    // Bits needed to index n items (at least 1).
    function automatic int unsigned calc_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned calc_beat_bytes(input int unsigned bw);
        return bw / 8;
    endfunction

endpackage

// File: rtl/wide_dmem_sequencer.sv
// Sequences scalar (32-bit) and wide vector (DATA_W-bit) data-memory accesses onto a
// single BEAT_W-wide memory port. Wide accesses are split into NBEATS beats.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/wide/we/addr/wdata*   MA-stage request (held while stall=1)
//   stall                           to MAREGstall (combinational in IDLE)
//   done                            one-cycle completion pulse
//   rdata, rdata_wide               last scalar / wide load result
//   mem_req/we/addr/wdata           beat request to memory
//   mem_gnt, mem_rvalid, mem_rdata  memory handshake and read data
//   err                             sticky timeout flag
// Optional feature: define TIMEOUT_EN to abort an access after TIMEOUT stalled cycles.
module wide_dmem_sequencer
    import shinku_ma_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned BEAT_W  = DEF_BEAT_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wide,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [DATA_W-1:0] req_wdata_wide,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [DATA_W-1:0] rdata_wide,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              err
);

    localparam int unsigned NBEATS = calc_nbeats(DATA_W, BEAT_W);
    localparam int unsigned IDX_W  = calc_idx_w(NBEATS);
    localparam int unsigned PAD_W  = NBEATS * BEAT_W;
    localparam int unsigned ASM_W  = (NBEATS - 1) * BEAT_W;
    localparam int unsigned STEP   = calc_beat_bytes(BEAT_W);
    localparam logic [IDX_W-1:0] LAST_WIDE = IDX_W'(NBEATS - 1);

    seq_state_t        state, state_next;
    logic [IDX_W-1:0]  beat;
    logic              wide_q, we_q;
    logic [PAD_W-1:0]  wdata_pad_q;   // store payload, zero-padded to whole beats
    logic [ASM_W-1:0]  asm_q;         // all but the final read beat of a wide load
    logic              busy_c, beat_last_c, beat_done_c, advance_c;

`ifdef TIMEOUT_EN
    localparam int unsigned TMO_W = calc_idx_w(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_c;
`endif

    assign busy_c  = (state == ISSUE) || (state == WAIT_R);
    assign stall   = (state == IDLE) ? req_valid : busy_c;
    assign done    = (state == DONE);
    assign mem_req = (state == ISSUE);

    // Next-state and beat-progress decode
    always_comb begin
        state_next  = state;
        beat_last_c = wide_q ? (beat == LAST_WIDE) : 1'b1;
        beat_done_c = ((state == ISSUE) && mem_gnt && we_q) ||
                      ((state == WAIT_R) && mem_rvalid);
        advance_c   = beat_done_c && !beat_last_c;
        case (state)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   if (mem_gnt) state_next = we_q ? (beat_last_c ? DONE : ISSUE) : WAIT_R;
            WAIT_R:  if (mem_rvalid) state_next = beat_last_c ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
`ifdef TIMEOUT_EN
        timeout_c = 1'b0;
        // Abort only when no progress would be made this cycle
        if (busy_c && (state_next == state) && !advance_c &&
            (tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
            timeout_c  = 1'b1;
            state_next = DONE;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Request latch, beat sequencing and read assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat        <= '0;
            wide_q      <= 1'b0;
            we_q        <= 1'b0;
            wdata_pad_q <= '0;
            asm_q       <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_wide  <= '0;
        end else begin
            if ((state == IDLE) && req_valid) begin
                beat        <= '0;
                wide_q      <= req_wide;
                we_q        <= req_we;
                wdata_pad_q <= PAD_W'(req_wdata_wide);
                asm_q       <= '0;
                mem_we      <= req_we;
                mem_addr    <= req_addr;
                mem_wdata   <= req_wide ? req_wdata_wide[BEAT_W-1:0] : BEAT_W'(req_wdata);
            end
            if (advance_c) begin
                beat      <= beat + IDX_W'(1);
                mem_addr  <= mem_addr + 32'(STEP);
                mem_wdata <= BEAT_W'(wdata_pad_q >> ((32'(beat) + 32'd1) * BEAT_W));
            end
            if ((state == WAIT_R) && mem_rvalid) begin
                if (!wide_q)
                    rdata <= mem_rdata[31:0];
                else if (beat_last_c)
                    rdata_wide <= DATA_W'({mem_rdata, asm_q});   // bits beyond DATA_W dropped
                else
                    asm_q <= asm_q | (ASM_W'(mem_rdata) << (32'(beat) * BEAT_W));
            end
            if (state_next == DONE) mem_we <= 1'b0;
        end
    end

`ifdef TIMEOUT_EN
    // Stall-cycle counter restarts on every state entry or beat advance; err is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if ((state_next != state) || advance_c) tmo_cnt <= '0;
            else if (busy_c)                        tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (timeout_c) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wide_dmem_sequencer.sv
// Scoreboard bench for wide_dmem_sequencer: a memory responder with random grant/read
// latency checks every beat against expected beats, and a monitor checks each done
// pulse against the expected load results computed from a reference memory.
module tb_wide_dmem_sequencer;

    localparam int unsigned DATA_W = 1048;
    localparam int unsigned BEAT_W = 128;
    localparam int unsigned NB     = 9;
    localparam int unsigned PAD_W  = NB * BEAT_W;
    localparam int unsigned TMO    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0, req_wide = 1'b0, req_we = 1'b0;
    logic [31:0]       req_addr = '0, req_wdata = '0;
    logic [DATA_W-1:0] req_wdata_wide = '0;
    logic              stall, done, mem_req, mem_we, err;
    logic [31:0]       rdata, mem_addr;
    logic [DATA_W-1:0] rdata_wide;
    logic [BEAT_W-1:0] mem_wdata;
    logic              mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [BEAT_W-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    wide_dmem_sequencer #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wide(req_wide), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wdata_wide(req_wdata_wide),
        .stall(stall), .done(done), .rdata(rdata), .rdata_wide(rdata_wide),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory as seen by the DUT (phys) and as predicted by the model (ref), keyed by beat address
    logic [BEAT_W-1:0] phys_mem [bit [31:0]];
    logic [BEAT_W-1:0] ref_mem  [bit [31:0]];

    function automatic logic [BEAT_W-1:0] fill(input bit [31:0] a);
        return {a * 32'd3 + 32'd1, ~a, a ^ 32'hDEADBEEF, a};
    endfunction
    function automatic logic [BEAT_W-1:0] phys_rd(input bit [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : fill(a);
    endfunction
    function automatic logic [BEAT_W-1:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    typedef struct { logic [31:0] addr; logic we; logic [BEAT_W-1:0] wdata; } beat_t;
    typedef struct { logic [31:0] rdata; logic [DATA_W-1:0] rdata_wide; } exp_t;
    beat_t beat_q[$];
    exp_t  exp_q[$];
    logic [31:0]       m_rdata = '0;
    logic [DATA_W-1:0] m_wide  = '0;

    // Responder control shared with stimulus
    int gnt_wait = 0;
    int beats_granted = 0;
    bit no_gnt = 1'b0;

    // Build the expected beats and result, then present the request
    task automatic issue(input bit wide, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [DATA_W-1:0] wdw, input bit expect_done);
        logic [PAD_W-1:0] acc;
        beat_t b;
        int n;
        n = wide ? NB : 1;
        acc = '0;
        for (int k = 0; k < n; k++) begin
            b.addr  = addr + 32'(16 * k);
            b.we    = we;
            b.wdata = wide ? BEAT_W'(wdw >> (k * BEAT_W)) : BEAT_W'(wd);
            beat_q.push_back(b);
            if (we) ref_mem[b.addr] = b.wdata;
            else    acc = acc | (PAD_W'(ref_rd(b.addr)) << (k * BEAT_W));
        end
        if (!we) begin
            if (wide) m_wide  = DATA_W'(acc);
            else      m_rdata = acc[31:0];
        end
        if (expect_done) exp_q.push_back('{m_rdata, m_wide});
        @(negedge clk);
        req_wide = wide; req_we = we; req_addr = addr; req_wdata = wd;
        req_wdata_wide = wdw; req_valid = 1'b1;
        if (expect_done) begin
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (done) break;
            end
            if (!done) fail_now("done_timeout");
            req_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_wide();
        logic [1055:0] t;
        for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
        return DATA_W'(t);
    endfunction

    // Memory responder: drives gnt/rvalid for the current cycle just after each rising edge
    initial begin
        bit rd_pend, waiting;
        int rd_cnt;
        logic [BEAT_W-1:0] rd_data;
        logic [31:0] prev_addr;
        beat_t e;
        rd_pend = 0; waiting = 0; rd_cnt = 0; rd_data = '0; prev_addr = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            if (!rst_n) begin
                rd_pend = 0;
                waiting = 0;
                continue;
            end
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_data;
                    rd_pend    = 0;
                end else rd_cnt--;
            end else if (mem_req) begin
                chk("stall_busy", DATA_W'(stall), DATA_W'(1));
                if (waiting) chk("addr_stable", DATA_W'(mem_addr), DATA_W'(prev_addr));
                if (gnt_wait == 0 && !no_gnt) begin
                    mem_gnt = 1'b1;
                    waiting = 0;
                    beats_granted++;
                    if (beat_q.size() == 0) fail_now("unexpected_beat");
                    else begin
                        e = beat_q.pop_front();
                        chk("beat_addr", DATA_W'(mem_addr), DATA_W'(e.addr));
                        chk("beat_we", DATA_W'(mem_we), DATA_W'(e.we));
                        if (e.we) chk("beat_wdata", DATA_W'(mem_wdata), DATA_W'(e.wdata));
                    end
                    if (mem_we) phys_mem[mem_addr] = mem_wdata;
                    else begin
                        rd_pend = 1;
                        rd_cnt  = $urandom_range(0, 3);
                        rd_data = phys_rd(mem_addr);
                    end
                    gnt_wait = $urandom_range(0, 3);
                end else begin
                    if (gnt_wait > 0) gnt_wait--;
                    waiting   = 1;
                    prev_addr = mem_addr;
                end
            end else begin
                // Stray handshakes outside their states must be ignored
                if ($urandom_range(0, 3) == 0) mem_gnt = 1'b1;
                if ($urandom_range(0, 3) == 0) mem_rvalid = 1'b1;
            end
        end
    end

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            chk("stall_in_done", DATA_W'(stall), DATA_W'(0));
            if (exp_q.size() == 0) fail_now("unexpected_done");
            else begin
                e = exp_q.pop_front();
                chk("rdata", DATA_W'(rdata), DATA_W'(e.rdata));
                chk("rdata_wide", rdata_wide, e.rdata_wide);
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] w;
        bit wide, we;
        logic [31:0] a;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_stall", DATA_W'(stall), '0);
        chk("rst_mem_req", DATA_W'(mem_req), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_done", DATA_W'(done), '0);
        chk("rst_mem_we", DATA_W'(mem_we), '0);
        chk("rst_mem_addr", DATA_W'(mem_addr), '0);
        chk("rst_mem_wdata", DATA_W'(mem_wdata), '0);
        chk("rst_rdata", DATA_W'(rdata), '0);
        chk("rst_rdata_wide", rdata_wide, '0);
        chk("rst_err", DATA_W'(err), '0);

        // Scalar load of a known word
        phys_mem[32'h100] = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEADBEEF};
        ref_mem[32'h100]  = phys_mem[32'h100];
        gnt_wait = 0;
        issue(1'b0, 1'b0, 32'h100, '0, '0, 1'b1);
        chk("scalar_deadbeef", DATA_W'(rdata), DATA_W'(32'hDEADBEEF));

        // Wide store then read back through memory
        w = rand_wide();
        issue(1'b1, 1'b1, 32'h1000, '0, w, 1'b1);
        issue(1'b1, 1'b0, 32'h1000, '0, '0, 1'b1);
        chk("wide_roundtrip", rdata_wide, w);

        // Wide load with per-beat pattern
        for (int k = 0; k < NB; k++) begin
            phys_mem[32'h2000 + 32'(16 * k)] = {8{16'(k)}};
            ref_mem[32'h2000 + 32'(16 * k)]  = {8{16'(k)}};
        end
        issue(1'b1, 1'b0, 32'h2000, '0, '0, 1'b1);

        // Grant withheld for 5 cycles
        gnt_wait = 5;
        issue(1'b0, 1'b1, 32'h140, 32'hCAFE_F00D, '0, 1'b1);

        // Randomized mix over a shared region
        for (int t = 0; t < 40; t++) begin
            wide = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            a    = 32'h4000 + 32'(16 * $urandom_range(0, 31));
            issue(wide, we, a, $urandom, rand_wide(), 1'b1);
        end

        // Reset asserted while beat 4 of a wide load is being requested
        beats_granted = 0;
        issue(1'b1, 1'b0, 32'h3000, '0, '0, 1'b0);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (beats_granted >= 4 && mem_req && mem_addr == 32'h3040) break;
        end
        if (!(mem_req && mem_addr == 32'h3040)) fail_now("beat4_not_reached");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", DATA_W'(mem_req), '0);
        chk("rst_mid_stall_req", DATA_W'(stall), DATA_W'(1));
        req_valid = 1'b0;
        #1;
        chk("rst_mid_stall_idle", DATA_W'(stall), '0);
        beat_q.delete();
        m_rdata = '0;
        m_wide  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gnt_wait = 0;
        issue(1'b0, 1'b1, 32'h180, 32'h1234_5678, '0, 1'b1);
        issue(1'b0, 1'b0, 32'h180, '0, '0, 1'b1);
        chk("post_rst_rdata", DATA_W'(rdata), DATA_W'(32'h1234_5678));

`ifdef TIMEOUT_EN
        // No grant ever: access aborted with sticky err
        no_gnt = 1'b1;
        issue(1'b0, 1'b1, 32'h1C0, 32'h5555_AAAA, '0, 1'b1);
        chk("timeout_err", DATA_W'(err), DATA_W'(1));
        repeat (4) @(negedge clk);
        chk("timeout_err_sticky", DATA_W'(err), DATA_W'(1));
        beat_q.delete();
`else
        chk("err_tied_low", DATA_W'(err), '0);
`endif

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) fail_now("pending_done");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
